lsu_store_buffer: RTL and testbench
===================================

Name: lsu_store_buffer

Overview:
Parametrised load/store unit for the memory stage. It replaces the direct pipeline-to-cache connection with a word-wide memory bus fronted by a configurable-depth posted store buffer. Stores retire in one cycle unless the buffer is full. Loads perform byte-lane alignment and sign extension, detect misaligned accesses, and stall on a same-word hazard with any buffered store. The block sits between the execute/memory pipeline register and the data cache or backing memory request port.

Parameters:
DATA_WIDTH, 32, data word width; only 32 is supported, since type_control encodes byte/half/word.
ADDR_WIDTH, 32, byte address width.
SB_DEPTH, 4, store-buffer entries; power of two, at least 2.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
mem_read  in  1  load request this cycle.
mem_write  in  1  store request this cycle; mem_read and mem_write are never both high.
type_control  in  2  00 byte, 01 half, 10 word, 11 treated as word.
sign_ext_flag  in  1  sign-extend byte/half loads.
addr  in  ADDR_WIDTH  byte address.
write_data  in  DATA_WIDTH  store data in the low bits.
read_data  out  DATA_WIDTH  aligned and extended load result; valid in the cycle a load completes.
mem_stall  out  1  pipeline must hold all inputs stable while high.
misaligned  out  1  access fault; combinational.
sb_empty  out  1  store buffer holds no entries.
bus_req  out  1  memory transfer request.
bus_we  out  1  1 = write, 0 = read.
bus_addr  out  ADDR_WIDTH  word-aligned address; bits [1:0] are always 0.
bus_wdata  out  DATA_WIDTH  lane-positioned write data.
bus_wstrb  out  DATA_WIDTH/8  byte strobes.
bus_rdata  in  DATA_WIDTH  read data; valid when bus_ready is high.
bus_ready  in  1  transfer completes in any cycle where bus_req and bus_ready are both high.

Behaviour:
- Reset:
  - FIFO pointers and count cleared; all entries invalid; state IDLE.
  - bus_req = 0, mem_stall = 0, read_data = 0, sb_empty = 1.
  - Pending stores are discarded. A bus transfer in flight is abandoned; bus_req is low after the reset edge.
- Misalignment:
  - Fault when a half access has addr[0] = 1, or a word access has addr[1:0] != 0.
  - misaligned = 1 in the same cycle.
  - No enqueue and no bus activity; mem_stall = 0.
- Store acceptance:
  - Accepted when mem_write is high, not misaligned, and count < SB_DEPTH.
  - Enqueued at the edge as {addr word, write_data shifted to lane addr[1:0], strobe}, with mem_stall = 0.
  - Strobes: byte 0001 << addr[1:0]; half 0011 << addr[1:0]; word 1111.
  - When count == SB_DEPTH, mem_stall = 1. This uses the registered count, so a drain completing in the same cycle does not unstall that cycle.
  - An enqueue and a dequeue in the same cycle leave count unchanged.
  - Pointers wrap modulo SB_DEPTH.
- Load hazard:
  - A load whose word address matches any valid entry stalls (mem_stall = 1) until no match remains.
  - The buffer keeps draining during the stall.
- FSM states:
  - IDLE: bus_req = 0. Transitions, in priority order:
    1. A load that is not misaligned and has no hazard: latch the word address, addr[1:0], type and sign flag, then go to LOAD. mem_stall = 1 this cycle.
    2. Otherwise, if the buffer is non-empty, go to DRAIN.
    3. A load has priority over draining only when there is no hazard.
  - DRAIN: bus_req = 1, bus_we = 1, bus signals driven from the head entry, held stable until bus_ready. On bus_ready, pop the head and go to IDLE. A load arriving during DRAIN stalls until the FSM returns to IDLE.
  - LOAD: bus_req = 1, bus_we = 0, bus_addr = latched address, bus_wstrb = 0.
    - On bus_ready: read_data is driven combinationally from bus_rdata, shifted right by 8*offset and zero- or sign-extended per type.
    - mem_stall = 0 in that cycle; go to IDLE.
    - Before bus_ready, mem_stall = 1 and read_data holds its previous value.
- Load latency: with bus_ready tied high, a load stalls for exactly 1 cycle and completes in the 2nd cycle.
- sb_empty is derived from the registered count.
- Stores always drain in program order.

Test Plan:
- Store word 0xDEADBEEF to 0x100 with bus_ready = 1: no stall; next cycles show bus_req = 1, bus_we = 1, bus_addr = 0x100, bus_wstrb = 1111; sb_empty returns to 1.
- Store byte 0xAB to 0x103: bus_wdata = 0xAB000000, bus_wstrb = 1000. Then load byte signed from 0x103 with bus_rdata = 0xAB000000: read_data = 0xFFFFFFAB. The same load unsigned returns 0x000000AB.
- Hold bus_ready = 0 and issue 5 stores: the first 4 are accepted and the 5th sees mem_stall = 1. Raise bus_ready: entries drain in order and the 5th store is accepted the cycle after count drops.
- Store to 0x200 with bus_ready low, then load from 0x202: load stalls until the 0x200 write completes, then issues a read to 0x200.
- Load half from 0x101 and store word to 0x102: misaligned = 1, mem_stall = 0, no bus_req, sb_empty stays 1.
- Assert rst during DRAIN with 3 entries: after the edge, bus_req = 0, sb_empty = 1, and no further writes occur.

Source files
------------

// File: rtl/lsu_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : lsu_store_buffer
// Description : Memory-stage load/store unit. Stores are posted into a small
//               in-order FIFO that drains to a word-wide bus when the bus is
//               otherwise idle. Loads are aligned and extended, are checked
//               for misalignment, and wait for any buffered store to the same
//               word before they issue.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_store_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int SB_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [1:0]              type_control,
    input  logic                    sign_ext_flag,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   write_data,
    output logic [DATA_WIDTH-1:0]   read_data,
    output logic                    mem_stall,
    output logic                    misaligned,
    output logic                    sb_empty,
    output logic                    bus_req,
    output logic                    bus_we,
    output logic [ADDR_WIDTH-1:0]   bus_addr,
    output logic [DATA_WIDTH-1:0]   bus_wdata,
    output logic [DATA_WIDTH/8-1:0] bus_wstrb,
    input  logic [DATA_WIDTH-1:0]   bus_rdata,
    input  logic                    bus_ready
);

    localparam int STRB_W  = DATA_WIDTH / 8;
    localparam int PTR_W   = $clog2(SB_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int WADDR_W = ADDR_WIDTH - 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    state_t                  state_q;
    logic [PTR_W-1:0]        head_q, tail_q;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [SB_DEPTH-1:0]     valid_q;
    logic [WADDR_W-1:0]      sb_addr_q [SB_DEPTH];
    logic [DATA_WIDTH-1:0]   sb_data_q [SB_DEPTH];
    logic [STRB_W-1:0]       sb_strb_q [SB_DEPTH];

    logic [WADDR_W-1:0]      ld_addr_q;
    logic [1:0]              ld_off_q;
    logic [1:0]              ld_type_q;
    logic                    ld_sign_q;
    logic [DATA_WIDTH-1:0]   rdata_q;

    logic [WADDR_W-1:0]      w_word_addr;
    logic [1:0]              w_off;
    logic                    w_full, w_empty, w_hazard;
    logic                    w_enq, w_deq, w_load_go, w_load_done;
    logic [DATA_WIDTH-1:0]   w_st_masked, w_st_data;
    logic [STRB_W-1:0]       w_st_strb;
    logic [DATA_WIDTH-1:0]   w_ld_shifted, w_ld_ext;

    assign w_word_addr = addr[ADDR_WIDTH-1:2];
    assign w_off       = addr[1:0];
    assign w_full      = (count_q == CNT_W'(SB_DEPTH));
    assign w_empty     = (count_q == '0);
    assign sb_empty    = w_empty;

    // Half accesses need an even address, word accesses (and code 11) need 4-byte alignment
    always_comb begin
        misaligned = 1'b0;
        if (mem_read || mem_write) begin
            if (type_control == 2'b01)
                misaligned = addr[0];
            else if (type_control[1])
                misaligned = (addr[1:0] != 2'b00);
        end
    end

    // A load must wait while any buffered store targets the same word
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (valid_q[i] && (sb_addr_q[i] == w_word_addr))
                w_hazard = 1'b1;
        end
        w_hazard = w_hazard & mem_read;
    end

    assign w_enq       = mem_write && !misaligned && !w_full;
    assign w_deq       = (state_q == ST_DRAIN) && bus_ready;
    assign w_load_go   = (state_q == ST_IDLE) && mem_read && !misaligned && !w_hazard;
    assign w_load_done = (state_q == ST_LOAD) && bus_ready;

    // Store data is trimmed to its size, then placed on its byte lanes with matching strobes
    always_comb begin
        case (type_control)
            2'b00: begin
                w_st_masked = {{(DATA_WIDTH-8){1'b0}}, write_data[7:0]};
                w_st_strb   = STRB_W'(1) << w_off;
            end
            2'b01: begin
                w_st_masked = {{(DATA_WIDTH-16){1'b0}}, write_data[15:0]};
                w_st_strb   = STRB_W'(3) << w_off;
            end
            default: begin
                w_st_masked = write_data;
                w_st_strb   = '1;
            end
        endcase
        w_st_data = w_st_masked << {w_off, 3'b000};
    end

    // Bring the addressed bytes down to bit 0 and extend to full width
    always_comb begin
        w_ld_shifted = bus_rdata >> {ld_off_q, 3'b000};
        case (ld_type_q)
            2'b00:   w_ld_ext = {{(DATA_WIDTH-8){ld_sign_q & w_ld_shifted[7]}}, w_ld_shifted[7:0]};
            2'b01:   w_ld_ext = {{(DATA_WIDTH-16){ld_sign_q & w_ld_shifted[15]}}, w_ld_shifted[15:0]};
            default: w_ld_ext = w_ld_shifted;
        endcase
    end

    assign read_data = w_load_done ? w_ld_ext : rdata_q;

    // Stall on a full buffer for stores, and for every load cycle except its completion
    always_comb begin
        mem_stall = 1'b0;
        if (!misaligned) begin
            if (mem_write && w_full)
                mem_stall = 1'b1;
            if (mem_read && !w_load_done)
                mem_stall = 1'b1;
        end
    end

    // Bus drive: head entry while draining, latched load address while loading
    always_comb begin
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        bus_wstrb = '0;
        case (state_q)
            ST_DRAIN: begin
                bus_req   = 1'b1;
                bus_we    = 1'b1;
                bus_addr  = {sb_addr_q[head_q], 2'b00};
                bus_wdata = sb_data_q[head_q];
                bus_wstrb = sb_strb_q[head_q];
            end
            ST_LOAD: begin
                bus_req  = 1'b1;
                bus_addr = {ld_addr_q, 2'b00};
            end
            default: ;
        endcase
    end

    // Occupancy next state: simultaneous push and pop cancel out
    always_comb begin
        case ({w_enq, w_deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Store FIFO: push at the tail, pop at the head, pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (w_deq) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_W'(1);
            end
            if (w_enq) begin
                sb_addr_q[tail_q] <= w_word_addr;
                sb_data_q[tail_q] <= w_st_data;
                sb_strb_q[tail_q] <= w_st_strb;
                valid_q[tail_q]   <= 1'b1;
                tail_q            <= tail_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // Bus sequencer: a hazard-free load wins over draining, one transfer at a time
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ld_addr_q <= '0;
            ld_off_q  <= 2'b00;
            ld_type_q <= 2'b00;
            ld_sign_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_load_go) begin
                        ld_addr_q <= w_word_addr;
                        ld_off_q  <= w_off;
                        ld_type_q <= type_control;
                        ld_sign_q <= sign_ext_flag;
                        state_q   <= ST_LOAD;
                    end else if (!w_empty) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (bus_ready)
                        state_q <= ST_IDLE;
                end
                ST_LOAD: begin
                    if (bus_ready) begin
                        rdata_q <= w_ld_ext;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_store_buffer
// Description : Directed self-checking bench for lsu_store_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_store_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [1:0]  type_control;
    logic        sign_ext_flag;
    logic [31:0] addr, write_data;
    logic [31:0] read_data;
    logic        mem_stall, misaligned, sb_empty;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_rdata;
    logic        bus_ready;

    int n_checks = 0;
    int n_errors = 0;

    lsu_store_buffer #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .SB_DEPTH   (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .type_control  (type_control),
        .sign_ext_flag (sign_ext_flag),
        .addr          (addr),
        .write_data    (write_data),
        .read_data     (read_data),
        .mem_stall     (mem_stall),
        .misaligned    (misaligned),
        .sb_empty      (sb_empty),
        .bus_req       (bus_req),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_wstrb     (bus_wstrb),
        .bus_rdata     (bus_rdata),
        .bus_ready     (bus_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Call right after step(); returns at the negedge of the first cycle with bus_req high
    task automatic wait_req(input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (bus_req) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        if (!seen)
            check("bus_req_timeout", 32'(bus_req), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; type_control = 2'b00;
        sign_ext_flag = 1'b0; addr = '0; write_data = '0; bus_rdata = '0; bus_ready = 1'b1;

        // Reset state
        step(); step();
        @(negedge clk);
        check("rst_bus_req",   32'(bus_req),   32'd0);
        check("rst_mem_stall", 32'(mem_stall), 32'd0);
        check("rst_read_data", read_data,      32'd0);
        check("rst_sb_empty",  32'(sb_empty),  32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Store word, drain with bus_ready high
        mem_write = 1'b1; type_control = 2'b10; addr = 32'h100; write_data = 32'hDEADBEEF;
        @(negedge clk);
        check("stw_stall", 32'(mem_stall),  32'd0);
        check("stw_mis",   32'(misaligned), 32'd0);
        step();
        mem_write = 1'b0;
        @(negedge clk);
        check("stw_sb_nonempty", 32'(sb_empty), 32'd0);
        step();
        wait_req(4);
        check("stw_we",    32'(bus_we),    32'd1);
        check("stw_addr",  bus_addr,       32'h100);
        check("stw_strb",  32'(bus_wstrb), 32'hF);
        check("stw_wdata", bus_wdata,      32'hDEADBEEF);
        step();
        @(negedge clk);
        check("stw_sb_empty", 32'(sb_empty), 32'd1);
        check("stw_req_done", 32'(bus_req),  32'd0);

        // Store byte to lane 3, then signed and unsigned byte loads
        step();
        mem_write = 1'b1; type_control = 2'b00; addr = 32'h103; write_data = 32'h000000AB;
        @(negedge clk);
        check("stb_stall", 32'(mem_stall),  32'd0);
        check("stb_mis",   32'(misaligned), 32'd0);
        step();
        mem_write = 1'b0;
        wait_req(4);
        check("stb_addr",  bus_addr,       32'h100);
        check("stb_wdata", bus_wdata,      32'hAB000000);
        check("stb_strb",  32'(bus_wstrb), 32'h8);
        step();
        mem_read = 1'b1; type_control = 2'b00; sign_ext_flag = 1'b1; addr = 32'h103;
        bus_rdata = 32'hAB000000;
        @(negedge clk);
        check("ldb_issue_stall", 32'(mem_stall), 32'd1);
        step();
        @(negedge clk);
        check("ldb_done_stall", 32'(mem_stall), 32'd0);
        check("ldb_signed",     read_data,      32'hFFFFFFAB);
        check("ldb_rd_we",      32'(bus_we),    32'd0);
        check("ldb_rd_addr",    bus_addr,       32'h100);
        check("ldb_rd_strb",    32'(bus_wstrb), 32'h0);
        step();
        sign_ext_flag = 1'b0;
        @(negedge clk);
        check("ldb_hold_rdata", read_data,      32'hFFFFFFAB);
        check("ldb_hold_stall", 32'(mem_stall), 32'd1);
        step();
        @(negedge clk);
        check("ldb_unsigned", read_data, 32'h000000AB);
        step();
        mem_read = 1'b0;

        // Fill the buffer with bus_ready low; fifth store stalls
        bus_ready = 1'b0;
        mem_write = 1'b1; type_control = 2'b10;
        for (int i = 0; i < 4; i++) begin
            addr = 32'h300 + 32'(4 * i); write_data = 32'(i + 1);
            @(negedge clk);
            check("fill_stall", 32'(mem_stall), 32'd0);
            step();
        end
        addr = 32'h310; write_data = 32'd5;
        @(negedge clk);
        check("full_stall",    32'(mem_stall), 32'd1);
        check("full_head_req", 32'(bus_req),   32'd1);
        check("full_head",     bus_addr,       32'h300);
        step();
        bus_ready = 1'b1;
        @(negedge clk);
        check("full_stall_same_cycle", 32'(mem_stall), 32'd1);
        check("full_head_data",        bus_wdata,      32'd1);
        step();
        @(negedge clk);
        check("full_unstall", 32'(mem_stall), 32'd0);
        step();
        mem_write = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_req(6);
            check("drain_order_addr", bus_addr,  32'h304 + 32'(4 * k));
            check("drain_order_data", bus_wdata, 32'(k + 2));
            step();
        end
        @(negedge clk);
        check("drain_sb_empty", 32'(sb_empty), 32'd1);

        // Same-word hazard: load waits for the buffered store, then reads
        step();
        bus_ready = 1'b0;
        mem_write = 1'b1; type_control = 2'b10; addr = 32'h200; write_data = 32'h55;
        @(negedge clk);
        check("hz_store_stall", 32'(mem_stall), 32'd0);
        step();
        mem_write = 1'b0;
        mem_read = 1'b1; type_control = 2'b01; sign_ext_flag = 1'b0; addr = 32'h202;
        @(negedge clk);
        check("hz_stall_idle", 32'(mem_stall), 32'd1);
        check("hz_no_req",     32'(bus_req),   32'd0);
        step();
        @(negedge clk);
        check("hz_stall_drain", 32'(mem_stall), 32'd1);
        check("hz_drain_we",    32'(bus_we),    32'd1);
        check("hz_drain_addr",  bus_addr,       32'h200);
        step();
        @(negedge clk);
        check("hz_stall_wait", 32'(mem_stall), 32'd1);
        step();
        bus_ready = 1'b1; bus_rdata = 32'h12340000;
        @(negedge clk);
        check("hz_stall_pop", 32'(mem_stall), 32'd1);
        step();
        @(negedge clk);
        check("hz_issue_stall", 32'(mem_stall), 32'd1);
        check("hz_issue_noreq", 32'(bus_req),   32'd0);
        step();
        @(negedge clk);
        check("hz_rd_req",   32'(bus_req),   32'd1);
        check("hz_rd_we",    32'(bus_we),    32'd0);
        check("hz_rd_addr",  bus_addr,       32'h200);
        check("hz_rd_data",  read_data,      32'h00001234);
        check("hz_rd_stall", 32'(mem_stall), 32'd0);
        step();
        mem_read = 1'b0;

        // Misaligned accesses are refused without bus activity
        mem_read = 1'b1; type_control = 2'b01; addr = 32'h101;
        @(negedge clk);
        check("mis_ldh",       32'(misaligned), 32'd1);
        check("mis_ldh_stall", 32'(mem_stall),  32'd0);
        check("mis_ldh_req",   32'(bus_req),    32'd0);
        step();
        mem_read = 1'b0;
        mem_write = 1'b1; type_control = 2'b10; addr = 32'h102; write_data = 32'h77;
        @(negedge clk);
        check("mis_stw",       32'(misaligned), 32'd1);
        check("mis_stw_stall", 32'(mem_stall),  32'd0);
        step();
        mem_write = 1'b0;
        @(negedge clk);
        check("mis_sb_empty", 32'(sb_empty), 32'd1);
        check("mis_no_req",   32'(bus_req),  32'd0);

        // Reset while draining discards entries and drops the request
        step();
        bus_ready = 1'b0;
        mem_write = 1'b1; type_control = 2'b10;
        for (int i = 0; i < 3; i++) begin
            addr = 32'h400 + 32'(4 * i); write_data = 32'hA0 + 32'(i);
            step();
        end
        mem_write = 1'b0;
        @(negedge clk);
        check("rstd_req_before",  32'(bus_req), 32'd1);
        check("rstd_addr_before", bus_addr,     32'h400);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rstd_req",       32'(bus_req),  32'd0);
        check("rstd_sb_empty",  32'(sb_empty), 32'd1);
        check("rstd_read_data", read_data,     32'd0);
        bus_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            @(negedge clk);
            check("rstd_no_write", 32'(bus_req), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
